gray_ptr_ctrl: RTL and testbench

//   Parametrised Gray-coded FIFO pointer controller for one clock domain of an async FIFO.
//   - Keeps a registered binary/Gray pointer pair.
//   - Synchronises the remote domain's Gray pointer and decodes it to binary.
//   - Produces a registered full flag (write side) or empty flag (read side), plus an occupancy count.
//   - Two instances, one per domain, form the control half of the CDC FIFO.

---
 rtl/gray_ptr_ctrl_pkg.sv | 25 ++
 rtl/gray_ptr_ctrl_sync_nff.sv | 37 +++
 rtl/gray_ptr_ctrl.sv | 81 ++++++++
 tb/tb_gray_ptr_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ptr_ctrl_pkg.sv
// Shared CDC helpers for the Gray-coded FIFO pointer controllers.
// Binary/Gray conversion works on a wide word; callers size-cast in and out.
package gray_ptr_ctrl_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;

    localparam int CDC_MAX_W = 32;

    typedef logic [CDC_MAX_W-1:0] cdc_word_t;

    function automatic cdc_word_t bin2gray(input cdc_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic cdc_word_t gray2bin(input cdc_word_t gray);
        cdc_word_t bin;
        bin[CDC_MAX_W-1] = gray[CDC_MAX_W-1];
        for (int i = CDC_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_ptr_ctrl_sync_nff.sv
// Multi-bit flop chain for a Gray-coded bus crossing into the local clock.
// Only valid for buses where at most one bit changes per source update.
module sync_nff #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [STAGES];
    logic [W-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int s = 1; s < STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One-domain pointer controller of an async FIFO: local bin/Gray pointer,
// synchronised remote pointer, registered full/empty flag and occupancy.
module gray_ptr_ctrl
    import gray_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic [ADDR_W:0]   remote_gray,
    output logic [ADDR_W:0]   ptr_gray,
    output logic [ADDR_W:0]   ptr_bin,
    output logic [ADDR_W-1:0] addr,
    output logic              flag,
    output logic [ADDR_W:0]   count
);

    localparam int   PTR_W    = ADDR_W + 1;
    localparam logic FLAG_RST = (MODE == MODE_RD);

    logic [PTR_W-1:0] ptr_bin_q, ptr_bin_d;
    logic [PTR_W-1:0] ptr_gray_q, ptr_gray_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;

    logic             accept;
    logic [PTR_W-1:0] rsync_gray;
    logic [PTR_W-1:0] rsync_bin;
    logic [PTR_W-1:0] full_cmp;

    sync_nff #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (remote_gray),
        .q     (rsync_gray)
    );

    // Flags are evaluated against the next pointer so they stay pessimistic.
    always_comb begin
        accept     = inc & ~flag_q;
        ptr_bin_d  = ptr_bin_q + {{ADDR_W{1'b0}}, accept};
        ptr_gray_d = PTR_W'(bin2gray(cdc_word_t'(ptr_bin_d)));
        rsync_bin  = PTR_W'(gray2bin(cdc_word_t'(rsync_gray)));
        full_cmp   = {~rsync_gray[ADDR_W:ADDR_W-1],
                      rsync_gray[ADDR_W-2:0]};
        if (MODE == MODE_WR) begin
            flag_d  = (ptr_gray_d == full_cmp);
            count_d = ptr_bin_d - rsync_bin;
        end else begin
            flag_d  = (ptr_gray_d == rsync_gray);
            count_d = rsync_bin - ptr_bin_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            count_q    <= '0;
            flag_q     <= FLAG_RST;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            count_q    <= count_d;
            flag_q     <= flag_d;
        end
    end

    assign ptr_gray = ptr_gray_q;
    assign ptr_bin  = ptr_bin_q;
    assign addr     = ptr_bin_q[ADDR_W-1:0];
    assign flag     = flag_q;
    assign count    = count_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl: a write-side and a read-side instance, DEPTH 4,
// checked against an occupancy-based reference through a scoreboard queue.
module tb_gray_ptr_ctrl;

    typedef struct packed {
        logic        rst;
        logic [1:0][2:0] pb;
        logic [1:0][2:0] cnt;
        logic [1:0]      fl;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       inc_w, inc_r;
    logic [2:0] remote_w, remote_r;
    logic [2:0] gray_w, bin_w, count_w;
    logic [2:0] gray_r, bin_r, count_r;
    logic [1:0] addr_w, addr_r;
    logic       flag_w, flag_r;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb[$];

    int         m_ptr [2];
    int         m_s0 [2];
    int         m_s1 [2];
    int         m_cnt [2];
    logic       m_flag [2];
    int         acc_cnt [2];
    logic [2:0] prev_g [2];

    gray_ptr_ctrl #(.ADDR_W(2), .MODE(0), .SYNC_STAGES(2)) u_wr (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (inc_w),
        .remote_gray (remote_w),
        .ptr_gray    (gray_w),
        .ptr_bin     (bin_w),
        .addr        (addr_w),
        .flag        (flag_w),
        .count       (count_w)
    );

    gray_ptr_ctrl #(.ADDR_W(2), .MODE(1), .SYNC_STAGES(2)) u_rd (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (inc_r),
        .remote_gray (remote_r),
        .ptr_gray    (gray_r),
        .ptr_bin     (bin_r),
        .addr        (addr_r),
        .flag        (flag_r),
        .count       (count_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int i = 0; i < 3; i++) b = b ^ (g >> i);
        return b & 7;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    task automatic cycle(input logic iw, input logic ir);
        exp_t e;
        logic acc, in;
        int nxt, rb, rem;
        @(negedge clk);
        inc_w = iw;
        inc_r = ir;
        e = '0;
        e.rst = ~rst_n;
        for (int s = 0; s < 2; s++) begin
            in  = (s == 0) ? iw : ir;
            rem = (s == 0) ? int'(remote_w) : int'(remote_r);
            if (!rst_n) begin
                m_ptr[s]  = 0;
                m_s0[s]   = 0;
                m_s1[s]   = 0;
                m_cnt[s]  = 0;
                m_flag[s] = (s == 1);
            end else begin
                acc = in && !m_flag[s];
                nxt = (m_ptr[s] + int'(acc)) & 7;
                rb  = g2b(m_s1[s]);
                if (s == 0) begin
                    m_cnt[s]  = (nxt - rb) & 7;
                    m_flag[s] = (m_cnt[s] == 4);
                end else begin
                    m_cnt[s]  = (rb - nxt) & 7;
                    m_flag[s] = (m_cnt[s] == 0);
                end
                m_s1[s]    = m_s0[s];
                m_s0[s]    = rem;
                m_ptr[s]   = nxt;
                acc_cnt[s] = acc_cnt[s] + int'(acc);
            end
            e.pb[s]  = 3'(m_ptr[s]);
            e.cnt[s] = 3'(m_cnt[s]);
            e.fl[s]  = m_flag[s];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wr_bin", bin_w, e.pb[0]);
        chk("wr_gray", gray_w, b2g(e.pb[0]));
        chk("wr_addr", addr_w, e.pb[0][1:0]);
        chk("wr_full", flag_w, e.fl[0]);
        chk("wr_count", count_w, e.cnt[0]);
        chk("rd_bin", bin_r, e.pb[1]);
        chk("rd_gray", gray_r, b2g(e.pb[1]));
        chk("rd_addr", addr_r, e.pb[1][1:0]);
        chk("rd_empty", flag_r, e.fl[1]);
        chk("rd_count", count_r, e.cnt[1]);
        if (!e.rst) begin
            chk("wr_gray_step", $countones(gray_w ^ prev_g[0]) <= 1, 1);
            chk("rd_gray_step", $countones(gray_r ^ prev_g[1]) <= 1, 1);
        end
        prev_g[0] = gray_w;
        prev_g[1] = gray_r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(0, 0);
        cycle(0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq [5];
        int guard;
        seq[0] = 3'b001;
        seq[1] = 3'b011;
        seq[2] = 3'b010;
        seq[3] = 3'b110;
        seq[4] = 3'b110;
        rst_n    = 1'b0;
        inc_w    = 1'b0;
        inc_r    = 1'b0;
        remote_w = '0;
        remote_r = '0;
        for (int s = 0; s < 2; s++) begin
            acc_cnt[s] = 0;
            prev_g[s]  = '0;
        end

        do_reset();
        chk("rst_full", flag_w, 0);
        chk("rst_empty", flag_r, 1);
        chk("rst_count_r", count_r, 0);

        // Write side fills, then a 5th push is refused.
        for (int k = 0; k < 5; k++) begin
            cycle(1, 0);
            chk("t1_gray", gray_w, seq[k]);
        end
        chk("t1_full", flag_w, 1);
        chk("t1_count", count_w, 4);
        chk("t1_hold", bin_w, 4);

        // Remote pop seen through the synchroniser reopens one slot.
        remote_w = 3'b001;
        cycle(1, 0);
        cycle(1, 0);
        chk("t5_full_still", flag_w, 1);
        cycle(1, 0);
        chk("t5_full_drop", flag_w, 0);
        chk("t5_bin_held", bin_w, 4);
        cycle(1, 0);
        chk("t5_refull", flag_w, 1);
        chk("t5_bin", bin_w, 5);

        do_reset();
        remote_w = '0;
        remote_r = 3'b010;
        cycle(0, 0);
        cycle(0, 0);
        chk("t2_empty_still", flag_r, 1);
        cycle(0, 0);
        chk("t2_empty_drop", flag_r, 0);
        chk("t2_count", count_r, 3);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1);
            if (k == 2) begin
                chk("t2_empty_again", flag_r, 1);
                chk("t2_count0", count_r, 0);
            end
        end
        chk("t2_hold", bin_r, 3);

        do_reset();
        remote_r = '0;
        for (int k = 0; k < 3; k++) cycle(1, 0);
        chk("t4_pre", bin_w, 3);
        rst_n = 1'b0;
        cycle(1, 0);
        chk("t4_bin", bin_w, 0);
        chk("t4_gray", gray_w, 0);
        chk("t4_count", count_w, 0);
        chk("t4_full", flag_w, 0);
        chk("t4_empty", flag_r, 1);
        rst_n = 1'b1;
        cycle(0, 0);
        chk("t4_no_acc", bin_w, 0);

        do_reset();
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        guard = 0;
        while ((acc_cnt[0] < 16 || acc_cnt[1] < 16) && guard < 200) begin
            remote_w = 3'(b2g(m_ptr[0]));
            remote_r = 3'(b2g((m_ptr[1] + 3) & 7));
            cycle(acc_cnt[0] < 16, acc_cnt[1] < 16);
            guard++;
        end
        chk("t3_done", guard < 200, 1);
        chk("t3_wr_gray", gray_w, 0);
        chk("t3_wr_bin", bin_w, 0);
        chk("t3_rd_gray", gray_r, 0);
        chk("t3_rd_bin", bin_r, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
